// File: rtl/cap_board_pkg.sv
// Shared constants, types and the reference decode for the capacitor-bank board decoder.
package cap_board_pkg;

  localparam int unsigned NUM_CAPS = 4;
  localparam int unsigned CODE_W   = 7;
  localparam int unsigned ADDR_W   = 6;

  // Wide enough for NUM_CAPS*A + i with headroom, and never narrower than the code.
  localparam int unsigned CMP_W =
      ((CODE_W > ADDR_W + $clog2(NUM_CAPS)) ? CODE_W : ADDR_W + $clog2(NUM_CAPS)) + 1;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [NUM_CAPS-1:0] cap_state_t;

  function automatic cap_state_t cap_decode(input code_t code, input addr_t addr);
    cap_state_t       res;
    addr_t            board;
    logic [CMP_W-1:0] base;
    logic [CMP_W-1:0] code_ext;
    board    = ~addr;
    base     = CMP_W'(NUM_CAPS) * CMP_W'(board);
    code_ext = CMP_W'(code);
    for (int i = 0; i < NUM_CAPS; i++) begin
      res[i] = (code != '0) && (code_ext >= base + CMP_W'(i));
    end
    return res;
  endfunction

endpackage

// File: rtl/cap_board_strobe_sync.sv
// Synchronizes the asynchronous update strobe and flags its rising edge for one clock.
module cap_board_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/cap_board_decoder.sv
// Per-board capacitor switch decoder: latches a thermometer slice of the shared tuning code
// on each synchronized rising edge of the strobe.
module cap_board_decoder #(
  parameter int unsigned NUM_CAPS    = cap_board_pkg::NUM_CAPS,
  parameter int unsigned CODE_W      = cap_board_pkg::CODE_W,
  parameter int unsigned ADDR_W      = cap_board_pkg::ADDR_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                enable,
  input  logic [CODE_W-1:0]   code,
  output logic [NUM_CAPS-1:0] state
);

  localparam int unsigned CmpW =
      ((CODE_W > ADDR_W + $clog2(NUM_CAPS)) ? CODE_W : ADDR_W + $clog2(NUM_CAPS)) + 1;

  logic                rise;
  logic [ADDR_W-1:0]   board;
  logic [CmpW-1:0]     base;
  logic [CmpW-1:0]     code_ext;
  logic [NUM_CAPS-1:0] state_d;
  logic [NUM_CAPS-1:0] state_q;

  cap_board_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(enable),
    .rise    (rise)
  );

  // Address pins are active low: switch ON reads as 0.
  assign board    = ~addr;
  assign base     = CmpW'(NUM_CAPS) * CmpW'(board);
  assign code_ext = CmpW'(code);

  always_comb begin
    state_d = '0;
    for (int i = 0; i < NUM_CAPS; i++) begin
      state_d[i] = (code != '0) && (code_ext >= base + CmpW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else if (rise) begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_cap_board_decoder.sv
// Directed table plus randomized strobes (with mid-strobe resets) for cap_board_decoder.
module tb_cap_board_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] addr;
  logic       enable;
  logic [6:0] code;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_prev;

  cap_board_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .enable(enable),
    .code  (code),
    .state (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [6:0] c;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[13];

  // Independent model: number of ON caps = code - base + 1, clamped to [0, 4].
  function automatic logic [3:0] ref_decode(input logic [6:0] c, input logic [5:0] a);
    int b;
    int n;
    b = 4 * (63 - int'(a));
    if (c == 7'd0) n = 0;
    else n = int'(c) - b + 1;
    if (n < 0) n = 0;
    if (n > 4) n = 4;
    return 4'((1 << n) - 1);
  endfunction

  task automatic check(input logic [3:0] act, input logic [3:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One strobe: high for 5 edges, then low; checks latency, single update and hold.
  task automatic strobe(input logic [5:0] a, input logic [6:0] c, input logic [3:0] exp,
                        input string name);
    @(negedge clk);
    addr   = a;
    code   = c;
    enable = 1'b1;
    @(posedge clk); #1;
    check(state, exp_prev, {name, "_lat_k"});
    @(posedge clk); #1;
    check(state, exp_prev, {name, "_lat_k1"});
    @(posedge clk); #1;
    check(state, exp, {name, "_update"});
    @(negedge clk);
    code = ~c;
    addr = ~a;
    repeat (2) begin
      @(posedge clk); #1;
      check(state, exp, {name, "_hold_high"});
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check(state, exp, {name, "_hold_low"});
      @(negedge clk);
      code = 7'($urandom_range(0, 127));
    end
    exp_prev = exp;
  endtask

  initial begin
    vecs[0]  = '{6'b110111, 7'd127, 4'b1111, "a8_c127"};
    vecs[1]  = '{6'b110111, 7'd33,  4'b0011, "a8_c33"};
    vecs[2]  = '{6'b110111, 7'd35,  4'b1111, "a8_c35"};
    vecs[3]  = '{6'b110111, 7'd31,  4'b0000, "a8_c31"};
    vecs[4]  = '{6'b110111, 7'd34,  4'b0111, "a8_c34"};
    vecs[5]  = '{6'b110111, 7'd0,   4'b0000, "a8_c0"};
    vecs[6]  = '{6'b111111, 7'd0,   4'b0000, "a0_c0"};
    vecs[7]  = '{6'b111111, 7'd1,   4'b0011, "a0_c1"};
    vecs[8]  = '{6'b111111, 7'd3,   4'b1111, "a0_c3"};
    vecs[9]  = '{6'b100000, 7'd124, 4'b0001, "a31_c124"};
    vecs[10] = '{6'b100000, 7'd127, 4'b1111, "a31_c127"};
    vecs[11] = '{6'b000000, 7'd127, 4'b0000, "a63_c127"};
    vecs[12] = '{6'b111110, 7'd5,   4'b0011, "a1_c5"};

    rst_n  = 1'b0;
    addr   = 6'b111111;
    code   = 7'h7F;
    enable = 1'b0;
    exp_prev = 4'b0000;

    // Strobe activity during reset must not update.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      enable = ~enable;
      @(posedge clk); #1;
      check(state, 4'b0000, "in_reset");
    end

    // Release with enable already high: the first synchronized high is an edge.
    @(negedge clk);
    enable = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    check(state, 4'b0000, "rel_k");
    @(posedge clk); #1;
    check(state, 4'b0000, "rel_k1");
    @(posedge clk); #1;
    check(state, 4'b1111, "rel_update");
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    exp_prev = 4'b1111;

    foreach (vecs[i]) strobe(vecs[i].a, vecs[i].c, vecs[i].exp, vecs[i].name);

    for (int it = 0; it < 24; it++) begin
      logic [5:0] ra;
      logic [6:0] rc;
      ra = ~6'($urandom_range(0, 33));
      rc = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) begin
        // Reset one edge into synchronization; the pending update must vanish.
        @(negedge clk);
        addr   = 6'b111111;
        code   = 7'd127;
        enable = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check(state, 4'b0000, "rnd_rst_async");
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
          @(posedge clk); #1;
          check(state, 4'b0000, "rnd_rst_discard");
        end
        exp_prev = 4'b0000;
      end else begin
        strobe(ra, rc, ref_decode(rc, ra), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cap_board_decoder.md
Name: cap_board_decoder

Overview:
- Per-board decoder for a QCM capacitor-bank tuning system: each board owns NUM_CAPS capacitor switches and a slice of a shared thermometer-style tuning code.
- The board's slice index comes from active-low DIP-switch address pins.
- On each rising edge of a strobe (enable), the board latches the current tuning code and drives its capacitor switch outputs (state) accordingly.
- Sits between the backplane code/strobe bus and the capacitor relay drivers.

Parameters:
- NUM_CAPS, 4, capacitor switches per board (width of state).
- CODE_W, 7, width of tuning code.
- ADDR_W, 6, width of board address pins.
- SYNC_STAGES, 2, synchronizer flops on enable (>=2).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_W  board address switches, active low (switch ON = logic 0).
- enable  input  1  asynchronous update strobe; an update is triggered by its rising edge.
- code  input  CODE_W  tuning code, unsigned; must be stable around the strobe.
- state  output  NUM_CAPS  capacitor switch states; bit i = 1 means capacitor i ON; registered.

Behaviour:
- Internal board index: A = ~addr (e.g. pins 6'b110111 -> A = 8).
- Base value: B = NUM_CAPS*A. Compute in at least ADDR_W+clog2(NUM_CAPS)+1 bits (9 bits at defaults); no truncation.
- Decode rule: next_state[i] = (code != 0) && (code >= B + i), for i = 0..NUM_CAPS-1.
  - Result is a thermometer pattern: LSBs fill first.
  - code >= B+NUM_CAPS-1 -> all ones.
  - code < B -> all zeros.
  - code = 0 -> all zeros for every A, including A = 0.
  - If B exceeds the maximum code value, the board is always all zeros.
- Enable path:
  - enable passes through SYNC_STAGES flops, then one history flop.
  - rise = sync_out & ~history.
- Update timing:
  - On a clk edge where rise = 1, state <= decode(code, addr), using code and addr as sampled at that edge.
  - At defaults: if enable is first sampled high at edge k, state changes at edge k+2.
- Hold: state is held at all other times.
  - Holding enable high causes exactly one update.
  - Changes on code or addr while enable is steady have no effect until the next rising edge of enable.
  - Falling edge of enable does nothing.
- Reset (rst_n = 0, asynchronous):
  - state = 0, all sync and history flops = 0.
  - If enable is already high when rst_n releases, the first synchronized high counts as a rising edge and performs one update.
  - Reset asserted mid-synchronization discards the pending update.
- Glitches on enable shorter than one clk period may be missed. Strobes must be high for at least 2 clk periods and low for at least 2 clk periods between updates.
- No combinational path from inputs to state.

Decomposition:
- Shared package cap_board_pkg:
  - default constants NUM_CAPS = 4, CODE_W = 7, ADDR_W = 6.
  - typedefs code_t, addr_t, cap_state_t.
  - a pure function cap_decode(code, addr) implementing the decode rule, so benches reuse it as the reference model.
- One sub-module, cap_board_strobe_sync: synchronizer plus rising-edge detector with parameter SYNC_STAGES and ports clk, rst_n, async_in, rise.
- Top level: decode logic and the state register.

Test Plan:
- Reset: rst_n low with code = 7'h7F, enable toggling -> state = 4'b0000 throughout reset; no update until after release.
- addr = 6'b110111 (A = 8), code = 7'b1111111, pulse enable for 5 clk cycles -> state = 4'b1111 exactly 2 clk edges after enable is first sampled high; exactly one update.
- Same addr, code = 7'b0100001 (33), pulse enable -> state = 4'b0011. Then code = 7'd35, pulse -> 4'b1111. Then code = 7'd31, pulse -> 4'b0000.
- Same addr, change code with enable held low, and separately with enable held high -> state unchanged. Then code = 0 and pulse enable -> state = 4'b0000.
- Boundary sweep:
  - addr = 6'b111111 (A = 0): code = 0 -> 4'b0000; code = 1 -> 4'b0011; code = 3 -> 4'b1111.
  - addr = 6'b100000 (A = 31, B = 124): code = 124 -> 4'b0001; code = 127 -> 4'b1111.
  - addr = 6'b000000 (A = 63): code = 127 -> 4'b0000.
- Random code/addr/strobe sequences, with reset asserted mid-strobe -> state matches cap_decode at each detected rising edge; reset clears state immediately and the interrupted strobe produces no update.
